// File: rtl/prf_freelist.sv
// Circular free list of physical register tags: grants up to two tags per cycle
// to rename, reclaims up to two stale tags per cycle from retirement, and rolls back on flush.
module prf_freelist #(
    parameter int PRF_SIZE = 64,
    parameter int ARF_SIZE = 32,
    parameter int PRF_IDX  = $clog2(PRF_SIZE),
    parameter int FL_DEPTH = PRF_SIZE - ARF_SIZE,
    parameter int PTR_W    = $clog2(FL_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_alloc_1,
    input  logic               i_alloc_2,
    output logic [PRF_IDX-1:0] o_free_reg_1,
    output logic [PRF_IDX-1:0] o_free_reg_2,
    output logic               o_free_valid_1,
    output logic               o_free_valid_2,
    output logic               o_stall,
    input  logic               i_retire_1,
    input  logic [PRF_IDX-1:0] i_retire_old_1,
    input  logic               i_retire_2,
    input  logic [PRF_IDX-1:0] i_retire_old_2,
    input  logic               i_flush,
    output logic [PTR_W-1:0]   o_spec_count,
    output logic               o_alloc_error,
    output logic               o_free_error
);

    localparam int IDX_W = PTR_W - 1;

    logic [PRF_IDX-1:0] r_list [FL_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_rhead;
    logic [PTR_W-1:0]   r_tail;
    logic               r_allocError;
    logic               r_freeError;

    logic [PTR_W-1:0]   w_specCount;
    logic [PTR_W-1:0]   w_headPlus1;
    logic [PTR_W-1:0]   w_nAlloc;
    logic [PTR_W-1:0]   w_nRetire;
    logic [PTR_W-1:0]   w_grant;
    logic [PTR_W-1:0]   w_wrPtr2;
    logic [PTR_W-1:0]   w_rheadNext;
    logic [PTR_W:0]     w_occupancyAfterPush;
    logic               w_allocErr;
    logic               w_freeErr;

    assign w_specCount  = r_tail - r_head;
    assign w_headPlus1  = r_head + PTR_W'(1);
    assign o_free_reg_1 = r_list[r_head[IDX_W-1:0]];
    assign o_free_reg_2 = r_list[w_headPlus1[IDX_W-1:0]];
    assign o_free_valid_1 = (w_specCount >= PTR_W'(1));
    assign o_free_valid_2 = (w_specCount >= PTR_W'(2));
    assign o_stall        = (w_specCount <  PTR_W'(2));
    assign o_spec_count   = w_specCount;
    assign o_alloc_error  = r_allocError;
    assign o_free_error   = r_freeError;

    assign w_nAlloc  = PTR_W'(i_alloc_1) + PTR_W'(i_alloc_2);
    assign w_nRetire = PTR_W'(i_retire_1) + PTR_W'(i_retire_2);

    // Grants only see the current head; a short list serves the older slot first.
    assign w_allocErr = !i_flush && (w_nAlloc > w_specCount);
    assign w_grant    = i_flush ? '0 : (w_allocErr ? w_specCount : w_nAlloc);

    // tail - rhead stays at FL_DEPTH, so overflow means retiring more tags than are in flight.
    assign w_occupancyAfterPush = {1'b0, w_specCount} + {1'b0, w_nRetire};
    assign w_freeErr   = (w_occupancyAfterPush > (PTR_W+1)'(FL_DEPTH));
    assign w_wrPtr2    = r_tail + PTR_W'(i_retire_1);
    assign w_rheadNext = w_freeErr ? r_rhead : (r_rhead + w_nRetire);

    // Flush rewinds head to the post-retire rhead so every speculative grant returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_list[i] <= PRF_IDX'(ARF_SIZE + i);
            end
            r_head       <= '0;
            r_rhead      <= '0;
            r_tail       <= PTR_W'(FL_DEPTH);
            r_allocError <= 1'b0;
            r_freeError  <= 1'b0;
        end else begin
            if (!w_freeErr && i_retire_1) begin
                r_list[r_tail[IDX_W-1:0]] <= i_retire_old_1;
            end
            if (!w_freeErr && i_retire_2) begin
                r_list[w_wrPtr2[IDX_W-1:0]] <= i_retire_old_2;
            end
            r_tail       <= w_freeErr ? r_tail : (r_tail + w_nRetire);
            r_rhead      <= w_rheadNext;
            r_head       <= i_flush ? w_rheadNext : (r_head + w_grant);
            r_allocError <= w_allocErr;
            r_freeError  <= w_freeErr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((r_head - r_rhead) <= (r_tail - r_rhead));
            assert (w_specCount <= PTR_W'(FL_DEPTH));
        end
    end

endmodule

// File: tb/tb_prf_freelist.sv
// Self-checking bench for prf_freelist: directed scenarios then random traffic,
// compared against a queue-based model of available and in-flight tags.
module tb_prf_freelist;

    localparam int PRF_IDX  = 6;
    localparam int PTR_W    = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               alloc1 = 1'b0;
    logic               alloc2 = 1'b0;
    logic               retire1 = 1'b0;
    logic               retire2 = 1'b0;
    logic [PRF_IDX-1:0] retireOld1 = '0;
    logic [PRF_IDX-1:0] retireOld2 = '0;
    logic               flush = 1'b0;
    logic [PRF_IDX-1:0] freeReg1;
    logic [PRF_IDX-1:0] freeReg2;
    logic               freeValid1;
    logic               freeValid2;
    logic               stall;
    logic [PTR_W-1:0]   specCount;
    logic               allocError;
    logic               freeError;

    int errors = 0;
    int checks = 0;

    int avail[$];
    int inflight[$];
    bit expAllocErr;
    bit expFreeErr;

    always #5 clock = ~clock;

    prf_freelist dut (
        .clock          (clock),
        .reset          (reset),
        .i_alloc_1      (alloc1),
        .i_alloc_2      (alloc2),
        .o_free_reg_1   (freeReg1),
        .o_free_reg_2   (freeReg2),
        .o_free_valid_1 (freeValid1),
        .o_free_valid_2 (freeValid2),
        .o_stall        (stall),
        .i_retire_1     (retire1),
        .i_retire_old_1 (retireOld1),
        .i_retire_2     (retire2),
        .i_retire_old_2 (retireOld2),
        .i_flush        (flush),
        .o_spec_count   (specCount),
        .o_alloc_error  (allocError),
        .o_free_error   (freeError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model state: avail is the allocatable list in order, inflight the granted-but-uncommitted tags.
    task automatic modelReset();
        avail.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) avail.push_back(32 + i);
        expAllocErr = 1'b0;
        expFreeErr  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".spec"},   32'(specCount),  32'(avail.size()));
        chk({tag, ".valid1"}, 32'(freeValid1), 32'(avail.size() >= 1));
        chk({tag, ".valid2"}, 32'(freeValid2), 32'(avail.size() >= 2));
        chk({tag, ".stall"},  32'(stall),      32'(avail.size() < 2));
        chk({tag, ".aerr"},   32'(allocError), 32'(expAllocErr));
        chk({tag, ".ferr"},   32'(freeError),  32'(expFreeErr));
        if (avail.size() >= 1) chk({tag, ".reg1"}, 32'(freeReg1), 32'(avail[0]));
        if (avail.size() >= 2) chk({tag, ".reg2"}, 32'(freeReg2), 32'(avail[1]));
    endtask

    task automatic doReset();
        reset = 1'b1;
        {alloc1, alloc2, retire1, retire2, flush} = '0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input string tag, input bit a1, input bit a2,
                                 input bit r1, input int o1, input bit r2, input int o2,
                                 input bit fl);
        int n;
        int m;
        int g;
        int granted[$];
        alloc1 = a1; alloc2 = a2; retire1 = r1; retire2 = r2; flush = fl;
        retireOld1 = PRF_IDX'(o1); retireOld2 = PRF_IDX'(o2);
        #3;
        checkOutput(tag);
        n = int'(a1) + int'(a2);
        m = int'(r1) + int'(r2);
        g = (n > avail.size()) ? avail.size() : n;
        expAllocErr = !fl && (n > avail.size());
        expFreeErr  = (m > inflight.size());
        if (!fl) repeat (g) granted.push_back(avail.pop_front());
        if (!expFreeErr) begin
            repeat (m) void'(inflight.pop_front());
            if (r1) avail.push_back(o1);
            if (r2) avail.push_back(o2);
        end
        foreach (granted[k]) inflight.push_back(granted[k]);
        if (fl) begin
            avail = {inflight, avail};
            inflight.delete();
        end
        @(posedge clock);
        #1;
        {alloc1, alloc2, retire1, retire2, flush} = '0;
    endtask

    task automatic idleCheck(input string tag);
        #3;
        checkOutput(tag);
    endtask

    initial begin
        // Reset state
        doReset();
        idleCheck("reset");
        chk("reset.reg1_const", 32'(freeReg1), 32);
        chk("reset.reg2_const", 32'(freeReg2), 33);
        chk("reset.spec_const", 32'(specCount), 32);

        // Drain the whole list two at a time
        for (int i = 0; i < 16; i++) begin
            #0 chk("drain.reg1_const", 32'(freeReg1), 32'(32 + 2 * i));
            applyStimulus("drain", 1, 1, 0, 0, 0, 0, 0);
        end
        idleCheck("empty");
        chk("empty.stall_const", 32'(stall), 1);
        chk("empty.valid1_const", 32'(freeValid1), 0);

        // Refill an empty list from retirement
        applyStimulus("refill", 0, 0, 1, 5, 1, 9, 0);
        idleCheck("refill");
        chk("refill.reg1_const", 32'(freeReg1), 5);
        chk("refill.reg2_const", 32'(freeReg2), 9);

        // Lone alloc_2 takes the head tag
        doReset();
        applyStimulus("alloc2only", 0, 1, 0, 0, 0, 0, 0);
        idleCheck("alloc2only");
        chk("alloc2only.reg1_const", 32'(freeReg1), 33);
        chk("alloc2only.spec_const", 32'(specCount), 31);

        // Speculative allocs rolled back by flush after partial retirement
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus("spec", 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("retire", 0, 0, 1, 1, 1, 2, 0);
        applyStimulus("flush", 0, 0, 0, 0, 0, 0, 1);
        idleCheck("flush");
        chk("flush.reg1_const", 32'(freeReg1), 34);
        chk("flush.spec_const", 32'(specCount), 32);

        // Over-allocation at spec_count = 1
        doReset();
        for (int i = 0; i < 15; i++) applyStimulus("fill31", 1, 1, 0, 0, 0, 0, 0);
        applyStimulus("fill31", 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("overalloc", 1, 1, 0, 0, 0, 0, 0);
        idleCheck("overalloc");
        chk("overalloc.aerr_const", 32'(allocError), 1);
        applyStimulus("overalloc.clear", 0, 0, 0, 0, 0, 0, 0);
        idleCheck("overalloc.clear");

        // Retiring with nothing in flight overflows the list
        doReset();
        applyStimulus("overfree", 0, 0, 1, 7, 0, 0, 0);
        idleCheck("overfree");
        chk("overfree.ferr_const", 32'(freeError), 1);

        // Random traffic
        doReset();
        for (int c = 0; c < 400; c++) begin
            bit a1, a2, r1, r2, fl;
            a1 = 1'($urandom_range(0, 1));
            a2 = 1'($urandom_range(0, 1));
            r1 = (inflight.size() > 0) && ($urandom_range(0, 2) != 0);
            r2 = (inflight.size() > 1) && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) r2 = 1'b1;
            fl = ($urandom_range(0, 23) == 0);
            applyStimulus("rand", a1, a2, r1, int'($urandom_range(0, 63)),
                          r2, int'($urandom_range(0, 63)), fl);
        end
        idleCheck("rand.end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
